// File: rtl/uart_rx_deframer_if.sv
// Deframer-side signal bundle: serial line in, parallel word and status pulses out.
// master is the receiver, slave is the line driver and consumer.
interface uart_rx_deframer_if #(
  parameter int unsigned FRAME_WIDTH = 8
);
  logic                   rx;
  logic [FRAME_WIDTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   frame_err;
  logic                   busy;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx, samples each bit at its midpoint and emits
// one-cycle rx_valid / frame_err pulses per frame.
module uart_rx_deframer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FRAME_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter int unsigned IDX_WIDTH    = 4
) (
  input logic                clk,
  input logic                rst,
  uart_rx_deframer_if.master bus
);

  localparam logic [CNT_WIDTH-1:0] CntHalf = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [IDX_WIDTH-1:0] IdxLast = IDX_WIDTH'(FRAME_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] shift_q, shift_d;
  logic [FRAME_WIDTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   rx_meta, rx_s;

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
            idx_d   = '0;
          end else begin
            // Start bit did not survive to its midpoint: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[FRAME_WIDTH-1:1]};
          if (idx_q == IdxLast) begin
            state_d = StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rx_s) begin
            // Leave mid stop bit so a back-to-back start edge is caught without slip.
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end

      StWaitHigh: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer: frames push expected events, the monitor pops
// and compares them against rx_valid / frame_err pulses.
module tb_uart_rx_deframer;

  localparam int unsigned Cpb     = 16;
  localparam int unsigned Fw      = 8;
  localparam int unsigned LatNom  = 155;

  typedef struct packed {
    logic        is_err;
    logic [7:0]  data;
    int unsigned start;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned cyc;
  int n_checks;
  int n_fail;
  int n_valid_seen;
  int n_err_seen;
  int exp_valid;
  int exp_err;
  logic [7:0] model_data;
  logic prev_pulse;
  exp_t sb_q[$];

  uart_rx_deframer_if #(.FRAME_WIDTH(Fw)) bus ();

  uart_rx_deframer #(
    .CLKS_PER_BIT(Cpb),
    .FRAME_WIDTH (Fw),
    .CNT_WIDTH   (16),
    .IDX_WIDTH   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is at #1 after a posedge; returns in the same phase. Sends the first nbits bits.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] bits;
    exp_t e;
    bits = {stop, d, 1'b0};
    e.is_err = ~stop;
    e.data   = d;
    e.start  = cyc;
    if (nbits == 10) begin
      sb_q.push_back(e);
      if (stop) exp_valid++;
      else exp_err++;
    end
    for (int i = 0; i < nbits; i++) begin
      bus.rx = bits[i];
      idle(Cpb);
    end
    bus.rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.rx_valid || bus.frame_err)) begin
      exp_t e;
      int unsigned lat;
      check("pulse_mutex", {31'd0, bus.rx_valid & bus.frame_err}, 32'd0);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        lat = cyc - e.start;
        check("latency_win", {31'd0, (lat >= LatNom - 1) && (lat <= LatNom + 1)}, 32'd1);
        check("pulse_kind", {31'd0, bus.frame_err}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.data});
          model_data = e.data;
        end else begin
          check("data_kept", {24'd0, bus.rx_data}, {24'd0, model_data});
        end
      end
      if (bus.rx_valid) n_valid_seen++;
      if (bus.frame_err) n_err_seen++;
    end
    prev_pulse = bus.rx_valid | bus.frame_err;
  end

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    n_valid_seen = 0;
    n_err_seen = 0;
    exp_valid = 0;
    exp_err = 0;
    model_data = 8'h00;
    prev_pulse = 1'b0;
    rst = 1'b1;
    bus.rx = 1'b1;
    idle(4);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Single frame
    send_frame(8'hA5, 1'b1, 10);
    idle(20);
    check("busy_after_a5", {31'd0, bus.busy}, 32'd0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    idle(20);

    // Short glitch on idle line
    bus.rx = 1'b0;
    idle(5);
    bus.rx = 1'b1;
    idle(4);
    check("glitch_busy", {31'd0, bus.busy}, 32'd1);
    idle(20);
    check("glitch_idle", {31'd0, bus.busy}, 32'd0);
    check("glitch_data", {24'd0, bus.rx_data}, 32'hFF);

    // Bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0, 10);
    idle(20);
    check("ferr_data", {24'd0, bus.rx_data}, 32'hFF);
    send_frame(8'h81, 1'b1, 10);
    idle(20);

    // Break: line held low for 40 bit times
    begin
      exp_t e;
      e.is_err = 1'b1;
      e.data   = 8'h00;
      e.start  = cyc;
      sb_q.push_back(e);
      exp_err++;
      bus.rx = 1'b0;
      idle(40 * Cpb);
      check("break_busy", {31'd0, bus.busy}, 32'd1);
      bus.rx = 1'b1;
      idle(5);
      check("break_idle", {31'd0, bus.busy}, 32'd0);
    end
    idle(20);

    // Reset in the middle of a frame
    send_frame(8'h55, 1'b1, 4);
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    idle(1);
    check("mrst_data", {24'd0, bus.rx_data}, 32'd0);
    check("mrst_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("mrst_err", {31'd0, bus.frame_err}, 32'd0);
    check("mrst_busy", {31'd0, bus.busy}, 32'd0);
    model_data = 8'h00;
    rst = 1'b0;
    idle(Cpb * 8);
    check("mrst_quiet", {31'd0, bus.busy}, 32'd0);
    send_frame(8'h66, 1'b1, 10);
    idle(30);

    check("sb_empty", sb_q.size(), 32'd0);
    check("valid_count", n_valid_seen, exp_valid);
    check("err_count", n_err_seen, exp_err);
    check("final_data", {24'd0, bus.rx_data}, 32'h66);
    check("final_busy", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- UART receive path: recovers serial frames from the asynchronous rx line and presents parallel bytes to the consumer.
- Frame format: 1 start bit (0), FRAME_WIDTH data bits LSB first, 1 stop bit (1). BITS_WIDTH = FRAME_WIDTH + 2.
- Same frame format as the transmit side of the UART.
- Mid-bit sampling uses an internal per-bit clock counter. Reports good frames and framing errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit; even, ≥ 4.
- FRAME_WIDTH, 8: data bits per frame.
- CNT_WIDTH, 16: width of the per-bit clock counter; must hold CLKS_PER_BIT-1.
- IDX_WIDTH, 4: width of the data bit index; must hold FRAME_WIDTH-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  FRAME_WIDTH  last correctly framed data word.
- rx_valid  output  1  one-cycle pulse: rx_data was updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchronizer:
  - rx passes through a 2-flop synchronizer; rx_s is the second flop.
  - Both flops reset to 1.
  - All logic below uses rx_s only.
- Reset values:
  - state = IDLE; counter = 0; bit index = 0; shift register = 0.
  - rx_data = 0; rx_valid = 0; frame_err = 0; busy = 0.
  - rst mid-frame aborts the frame immediately; no pulse is generated.
- Counter: increments every clk in START/DATA/STOP. Clears to 0 on every state transition and at each DATA bit boundary.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s == 0 -> START, counter = 0.
  - Otherwise remain in IDLE.
- START:
  - At counter == CLKS_PER_BIT/2 - 1, sample rx_s (mid start bit).
  - rx_s == 0 -> DATA, counter = 0, bit index = 0.
  - rx_s == 1 -> IDLE (glitch rejected, no pulse).
- DATA:
  - At counter == CLKS_PER_BIT - 1, shift rx_s into the shift register MSB and right-shift it, so the first bit ends in bit 0.
  - Then clear the counter and increment the bit index.
  - After the sample with bit index == FRAME_WIDTH - 1 -> STOP, counter = 0.
- STOP: at counter == CLKS_PER_BIT - 1, sample rx_s.
  - rx_s == 1: rx_data <= shift register; rx_valid = 1 for exactly the next cycle; -> IDLE.
  - rx_s == 0: frame_err = 1 for exactly the next cycle; rx_data unchanged; -> WAIT_HIGH.
- WAIT_HIGH: remain until rx_s == 1, then -> IDLE. A held-low line (break) therefore produces exactly one frame_err and no repeated frames.
- Pulses: rx_valid and frame_err are registered and mutually exclusive; neither stays high for more than 1 cycle.
- Back-to-back frames:
  - A start bit beginning immediately after the stop bit is accepted.
  - IDLE is entered mid stop bit, so the next falling edge is detected with no lost cycles.
- Consumer handshake: none. The consumer must capture rx_data on rx_valid; a later frame overwrites rx_data.
- Latency: rx_valid rises 2 + CLKS_PER_BIT/2 + (FRAME_WIDTH+1)*CLKS_PER_BIT + 1 cycles (±1) after the clk edge that first sees rx low. For defaults this is 155 ±1.
- Arithmetic: counter and index compare with ==; no wrap occurs within legal parameters.

Test Plan:
1. Reset, then drive frame 0xA5 (defaults, 16 clk/bit) -> rx_data = 0xA5, one rx_valid pulse at ~155 cycles after the falling edge, frame_err stays 0, busy returns to 0.
2. Two back-to-back frames 0x00 then 0xFF, no idle gap -> two rx_valid pulses 160 cycles apart, rx_data 0x00 then 0xFF.
3. rx low pulse of 5 cycles on an idle line -> return to IDLE, no rx_valid, no frame_err, rx_data unchanged.
4. Frame 0x3C with stop bit driven 0, line then high -> single frame_err pulse, rx_data keeps its previous value. A following frame 0x81 is received correctly.
5. Line held low for 40 bit times (break) -> exactly one frame_err, busy high until the line goes high, then IDLE; no rx_valid.
6. Assert rst during DATA of frame 0x55 -> all outputs at reset values next cycle, no pulse. A subsequent frame 0x66 is received correctly.
